// File: rtl/led_mux8.sv
// Scans eight active-low segment bytes onto a common-anode display, one digit per slot,
// with a blanking dead-time at the start of each slot and frame-level PWM brightness.
module led_mux8 #(
  parameter int SLOT_TICKS  = 100_000,
  parameter int BLANK_TICKS = 1_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [7:0] in4,
  input  logic [7:0] in5,
  input  logic [7:0] in6,
  input  logic [7:0] in7,
  input  logic [7:0] an_en,
  input  logic [3:0] bright,
  output logic [7:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);

  localparam int TW = (SLOT_TICKS > 2) ? $clog2(SLOT_TICKS) : 1;
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
  localparam logic [TW-1:0] ON_LAST    = TW'(SLOT_TICKS - BLANK_TICKS - 1);

  typedef enum logic {S_BLANK, S_ON} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tick, tick_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [3:0]    frame_cnt, frame_cnt_nxt;
  logic [7:0]    an_nxt, sseg_nxt;
  logic          frame_tick_nxt;
  logic [7:0]    digit_seg;
  logic          lit;

  always_comb begin
    digit_seg = 8'hFF;
    case (idx)
      3'd0: digit_seg = in0;
      3'd1: digit_seg = in1;
      3'd2: digit_seg = in2;
      3'd3: digit_seg = in3;
      3'd4: digit_seg = in4;
      3'd5: digit_seg = in5;
      3'd6: digit_seg = in6;
      3'd7: digit_seg = in7;
      default: digit_seg = 8'hFF;
    endcase
  end

  // PWM: a digit lights only in the first bright+1 frames of every 16
  assign lit = an_en[idx] && (frame_cnt <= bright);

  always_comb begin
    state_nxt      = state;
    tick_nxt       = tick + 1'b1;
    idx_nxt        = idx;
    frame_cnt_nxt  = frame_cnt;
    an_nxt         = an;
    sseg_nxt       = sseg;
    frame_tick_nxt = 1'b0;
    case (state)
      S_BLANK: begin
        if (tick == BLANK_LAST) begin
          state_nxt = S_ON;
          tick_nxt  = '0;
          an_nxt    = lit ? ~(8'b1 << idx) : 8'hFF;
          sseg_nxt  = lit ? digit_seg : 8'hFF;
        end
      end
      S_ON: begin
        if (tick == ON_LAST) begin
          state_nxt = S_BLANK;
          tick_nxt  = '0;
          an_nxt    = 8'hFF;
          sseg_nxt  = 8'hFF;
          idx_nxt   = idx + 3'd1;
          if (idx == 3'd7) begin
            frame_cnt_nxt  = frame_cnt + 4'd1;
            frame_tick_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = S_BLANK;
        tick_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_BLANK;
      tick       <= '0;
      idx        <= 3'd0;
      frame_cnt  <= 4'd0;
      an         <= 8'hFF;
      sseg       <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      tick       <= tick_nxt;
      idx        <= idx_nxt;
      frame_cnt  <= frame_cnt_nxt;
      an         <= an_nxt;
      sseg       <= sseg_nxt;
      frame_tick <= frame_tick_nxt;
    end
  end

endmodule
